// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative cache controller.
// Widths derive from module parameters, so they are exposed as constant functions.
package cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_FILL,
        S_WTHRU,
        S_DONE
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r++;
        end
        return r;
    endfunction

    // Lowest index bit: 2 byte-offset bits plus the word-in-line offset.
    function automatic int idx_lo(input int line_words);
        return 2 + clog2(line_words);
    endfunction

    function automatic int idx_w(input int sets);
        return clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_bits, input int sets, input int line_words);
        return addr_bits - idx_lo(line_words) - idx_w(sets);
    endfunction

    // Way and PLRU widths never drop below 1 so direct-mapped builds stay legal.
    function automatic int way_w(input int ways);
        return (ways > 1) ? clog2(ways) : 1;
    endfunction

    function automatic int plru_w(input int ways);
        return (ways > 1) ? ways - 1 : 1;
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: victim select and next tree bits after a touch.
// Node n (heap order, root = 1) lives in bits[n-1]; 0 steers the victim toward the lower half.
module plru_tree
    import cache_pkg::*;
#(
    parameter int WAYS = 2
) (
    input  logic [plru_w(WAYS)-1:0] bits,
    input  logic [way_w(WAYS)-1:0]  touch_way,
    output logic [way_w(WAYS)-1:0]  victim,
    output logic [plru_w(WAYS)-1:0] bits_next
);

    localparam int LVLS = clog2(WAYS);
    localparam int WW   = way_w(WAYS);

    always_comb begin
        int node;
        node = 1;
        for (int l = 0; l < LVLS; l++) begin
            node = 2 * node + int'(bits[node-1]);
        end
        victim = WW'(node - WAYS);

        bits_next = bits;
        node = 1;
        for (int l = LVLS - 1; l >= 0; l--) begin
            bits_next[node-1] = ~touch_way[l];
            node = 2 * node + int'(touch_way[l]);
        end
    end

endmodule

// File: rtl/set_assoc_cache_ctrl.sv
// N-way set-associative, write-through, no-write-allocate cache controller with
// tree-PLRU replacement, flush and saturating hit/access statistics.
module set_assoc_cache_ctrl
    import cache_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 2,
    parameter int ADDR_BITS  = 19
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en_in,
    input  logic                     wr_en_in,
    input  logic                     flush_in,
    input  logic [31:0]              adr_in,
    input  logic [31:0]              w_data_in,
    output logic [31:0]              r_data_out,
    output logic                     ready_out,
    output logic                     mem_rd_en_out,
    output logic                     mem_wr_en_out,
    output logic [31:0]              mem_adr_out,
    output logic [31:0]              mem_w_data_out,
    input  logic [32*LINE_WORDS-1:0] mem_r_data_in,
    input  logic                     mem_ready_in,
    output logic [31:0]              hit_cnt_out,
    output logic [31:0]              access_cnt_out
);

    localparam int IDX_LO = idx_lo(LINE_WORDS);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_BITS, SETS, LINE_WORDS);
    localparam int OFF_W  = (LINE_WORDS > 1) ? clog2(LINE_WORDS) : 1;
    localparam int WW     = way_w(WAYS);
    localparam int PW     = plru_w(WAYS);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t state_q, state_d;

    logic [WAYS-1:0]  valid_q [SETS];
    logic [PW-1:0]    plru_q  [SETS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [31:0]      data_q  [SETS][WAYS][LINE_WORDS];
    logic [31:0]      hit_cnt_q, access_cnt_q;

    logic [31:2] adr_p0;
    logic [31:0] wdata_p0;
    logic        is_wr_p0;
    logic [31:0] rdata_q;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [OFF_W-1:0] off;
    logic             hit, has_inv;
    logic [WW-1:0]    hit_way, inv_way, plru_victim, victim_way, touch_way;
    logic [PW-1:0]    plru_next;

    assign idx = adr_p0[IDX_LO +: IDX_W];
    assign tag = adr_p0[IDX_LO+IDX_W +: TAG_W];
    assign off = (LINE_WORDS > 1) ? adr_p0[2 +: OFF_W] : '0;

    // First matching valid way wins; the fill victim prefers the lowest empty way.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag && !hit) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
            if (!valid_q[idx][w] && !has_inv) begin
                has_inv = 1'b1;
                inv_way = WW'(w);
            end
        end
    end

    assign victim_way = has_inv ? inv_way : plru_victim;
    assign touch_way  = (state_q == S_FILL) ? victim_way : hit_way;

    plru_tree #(.WAYS(WAYS)) u_plru (
        .bits      (plru_q[idx]),
        .touch_way (touch_way),
        .victim    (plru_victim),
        .bits_next (plru_next)
    );

    always_comb begin
        state_d        = state_q;
        ready_out      = 1'b0;
        mem_rd_en_out  = 1'b0;
        mem_wr_en_out  = 1'b0;
        mem_adr_out    = '0;
        mem_w_data_out = '0;
        r_data_out     = '0;
        case (state_q)
            S_IDLE: begin
                if (!flush_in && (rd_en_in || wr_en_in)) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (is_wr_p0)  state_d = S_WTHRU;
                else if (hit)  state_d = S_DONE;
                else           state_d = S_FILL;
            end
            S_FILL: begin
                mem_rd_en_out = 1'b1;
                mem_adr_out   = {adr_p0[31:IDX_LO], {IDX_LO{1'b0}}};
                if (mem_ready_in) state_d = S_DONE;
            end
            S_WTHRU: begin
                mem_wr_en_out  = 1'b1;
                mem_adr_out    = {adr_p0, 2'b00};
                mem_w_data_out = wdata_p0;
                if (mem_ready_in) state_d = S_DONE;
            end
            S_DONE: begin
                ready_out  = 1'b1;
                r_data_out = is_wr_p0 ? 32'h0 : rdata_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state: FSM, valid bits, PLRU bits and statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            hit_cnt_q    <= '0;
            access_cnt_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && flush_in) begin
                for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
            end
            if (state_q == S_LOOKUP && hit) begin
                plru_q[idx] <= plru_next;
                hit_cnt_q   <= sat_inc(hit_cnt_q);
            end
            if (state_q == S_FILL && mem_ready_in) begin
                valid_q[idx][victim_way] <= 1'b1;
                plru_q[idx]              <= plru_next;
            end
            if (state_q == S_DONE) access_cnt_q <= sat_inc(access_cnt_q);
        end
    end

    // p0: request capture in IDLE; line storage and read-word latch follow it.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && !flush_in && (rd_en_in || wr_en_in)) begin
            adr_p0   <= adr_in[31:2];
            wdata_p0 <= w_data_in;
            is_wr_p0 <= wr_en_in;
        end
        if (state_q == S_LOOKUP && hit) begin
            if (is_wr_p0) data_q[idx][hit_way][off] <= wdata_p0;
            else          rdata_q <= data_q[idx][hit_way][off];
        end
        if (state_q == S_FILL && mem_ready_in) begin
            tag_q[idx][victim_way] <= tag;
            for (int i = 0; i < LINE_WORDS; i++) begin
                data_q[idx][victim_way][i] <= mem_r_data_in[32*i +: 32];
            end
            rdata_q <= mem_r_data_in[{off, 5'd0} +: 32];
        end
    end

    assign hit_cnt_out    = hit_cnt_q;
    assign access_cnt_out = access_cnt_q;

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Scoreboard bench for set_assoc_cache_ctrl (2 ways, 64 sets, 2-word lines):
// stimulus pushes hand-computed expectations, a monitor checks each ready_out pulse.
module tb_set_assoc_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en_in, wr_en_in, flush_in;
    logic [31:0] adr_in, w_data_in;
    logic [31:0] r_data_out;
    logic        ready_out;
    logic        mem_rd_en_out, mem_wr_en_out;
    logic [31:0] mem_adr_out, mem_w_data_out;
    logic [63:0] mem_r_data_in;
    logic        mem_ready_in;
    logic [31:0] hit_cnt_out, access_cnt_out;

    always #5 clk = ~clk;

    set_assoc_cache_ctrl #(
        .WAYS(2), .SETS(64), .LINE_WORDS(2), .ADDR_BITS(19)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rd_en_in       (rd_en_in),
        .wr_en_in       (wr_en_in),
        .flush_in       (flush_in),
        .adr_in         (adr_in),
        .w_data_in      (w_data_in),
        .r_data_out     (r_data_out),
        .ready_out      (ready_out),
        .mem_rd_en_out  (mem_rd_en_out),
        .mem_wr_en_out  (mem_wr_en_out),
        .mem_adr_out    (mem_adr_out),
        .mem_w_data_out (mem_w_data_out),
        .mem_r_data_in  (mem_r_data_in),
        .mem_ready_in   (mem_ready_in),
        .hit_cnt_out    (hit_cnt_out),
        .access_cnt_out (access_cnt_out)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        is_wr;
        logic        exp_hit;
        logic [31:0] adr;
        logic [31:0] wdata;
        int          lat;
        int          req_cyc;
        logic [31:0] hits;
        logic [31:0] acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          mem_lat = 3;
    int          busy;
    logic [31:0] mem_store [logic [31:0]];
    logic [31:0] exp_hits, exp_acc;
    logic        seen_rd, seen_wr, acc_pending;
    logic [31:0] seen_adr, seen_wdata, acc_exp_pending;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    always @(posedge clk) cyc++;

    // Memory: ready pulses in the mem_lat-th cycle of a request; writes are committed.
    initial begin
        busy = 0;
        mem_ready_in = 1'b0;
        mem_r_data_in = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready_in = 1'b0;
            if (!rst && (mem_rd_en_out || mem_wr_en_out)) begin
                busy++;
                if (busy >= mem_lat) begin
                    busy = 0;
                    mem_ready_in = 1'b1;
                    if (mem_rd_en_out) mem_r_data_in = {mem_word(mem_adr_out + 32'd4), mem_word(mem_adr_out)};
                    else               mem_store[mem_adr_out] = mem_w_data_out;
                end
            end else begin
                busy = 0;
            end
        end
    end

    // Monitor: records memory traffic per access, checks everything on ready_out.
    initial begin
        seen_rd = 1'b0;
        seen_wr = 1'b0;
        seen_adr = '0;
        seen_wdata = '0;
        acc_pending = 1'b0;
        acc_exp_pending = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen_rd = 1'b0;
                seen_wr = 1'b0;
                acc_pending = 1'b0;
            end else begin
                if (acc_pending) begin
                    check("access_cnt", access_cnt_out, acc_exp_pending);
                    acc_pending = 1'b0;
                end
                if (mem_rd_en_out) begin
                    seen_rd = 1'b1;
                    seen_adr = mem_adr_out;
                end
                if (mem_wr_en_out) begin
                    seen_wr = 1'b1;
                    seen_adr = mem_adr_out;
                    seen_wdata = mem_w_data_out;
                end
                if (ready_out) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_ready: got ready_out=1, expected no pending request");
                    end else begin
                        mon_e = sb.pop_front();
                        check("r_data", r_data_out, mon_e.rdata);
                        check("latency", 32'(cyc - mon_e.req_cyc), 32'(mon_e.lat));
                        check("mem_rd_seen", 32'(seen_rd), 32'(!mon_e.is_wr && !mon_e.exp_hit));
                        check("mem_wr_seen", 32'(seen_wr), 32'(mon_e.is_wr));
                        if (seen_rd || seen_wr) check("mem_adr", seen_adr, mon_e.adr);
                        if (mon_e.is_wr) check("mem_w_data", seen_wdata, mon_e.wdata);
                        check("hit_cnt", hit_cnt_out, mon_e.hits);
                        acc_pending = 1'b1;
                        acc_exp_pending = mon_e.acc;
                    end
                    seen_rd = 1'b0;
                    seen_wr = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic hit, input logic [31:0] exp_rd);
        exp_t e;
        int   t;
        @(negedge clk);
        exp_acc = exp_acc + 32'd1;
        if (hit) exp_hits = exp_hits + 32'd1;
        e.rdata   = wr ? 32'h0 : exp_rd;
        e.is_wr   = wr;
        e.exp_hit = hit;
        e.adr     = wr ? a : (hit ? 32'h0 : {a[31:3], 3'b000});
        e.wdata   = wd;
        e.lat     = (hit && !wr) ? 2 : 2 + mem_lat;
        e.req_cyc = cyc;
        e.hits    = exp_hits;
        e.acc     = exp_acc;
        sb.push_back(e);
        adr_in    = a;
        w_data_in = wd;
        rd_en_in  = !wr;
        wr_en_in  = wr;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ready_out && t < 40);
        if (!ready_out) begin
            n_checks++;
            $display("FAIL timeout: no ready_out within 40 cycles for adr %h, expected completion", a);
            void'(sb.pop_back());
        end
        @(posedge clk);
        #1;
        rd_en_in = 1'b0;
        wr_en_in = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        rd_en_in = 1'b0;
        wr_en_in = 1'b0;
        flush_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_hits = '0;
        exp_acc = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_seen;
        rst = 1'b1;
        rd_en_in = 1'b0;
        wr_en_in = 1'b0;
        flush_in = 1'b0;
        adr_in = '0;
        w_data_in = '0;
        exp_hits = '0;
        exp_acc = '0;
        mem_store[32'h400] = 32'h1111_1111;
        mem_store[32'h404] = 32'h2222_2222;

        do_reset();
        check("rst_ready", 32'(ready_out), 32'd0);
        check("rst_mem_rd_en", 32'(mem_rd_en_out), 32'd0);
        check("rst_mem_wr_en", 32'(mem_wr_en_out), 32'd0);
        check("rst_mem_adr", mem_adr_out, 32'd0);
        check("rst_r_data", r_data_out, 32'd0);
        check("rst_hit_cnt", hit_cnt_out, 32'd0);
        check("rst_access_cnt", access_cnt_out, 32'd0);

        // Fill then hit in the same line.
        issue(1'b0, 32'h400, 32'h0, 1'b0, 32'h1111_1111);
        issue(1'b0, 32'h404, 32'h0, 1'b1, 32'h2222_2222);

        // Write hit, read back; write miss does not allocate.
        issue(1'b1, 32'h404, 32'hDEAD_BEEF, 1'b1, 32'h0);
        issue(1'b0, 32'h404, 32'h0, 1'b1, 32'hDEAD_BEEF);
        issue(1'b1, 32'hA00, 32'h1234_5678, 1'b0, 32'h0);
        issue(1'b0, 32'hA00, 32'h0, 1'b0, 32'h1234_5678);

        // Flush wins over a simultaneous read; everything misses afterwards.
        @(negedge clk);
        flush_in = 1'b1;
        rd_en_in = 1'b1;
        adr_in = 32'h400;
        @(negedge clk);
        flush_in = 1'b0;
        rd_en_in = 1'b0;
        rdy_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ready_out) rdy_seen++;
        end
        check("flush_priority_ready", 32'(rdy_seen), 32'd0);
        issue(1'b0, 32'h400, 32'h0, 1'b0, 32'h1111_1111);
        issue(1'b0, 32'h404, 32'h0, 1'b1, 32'hDEAD_BEEF);

        // PLRU on set 0: 0x600 is least recently used when 0x800 arrives.
        do_reset();
        issue(1'b0, 32'h400, 32'h0, 1'b0, 32'h1111_1111);
        issue(1'b0, 32'h600, 32'h0, 1'b0, 32'hA5A5_0600);
        issue(1'b0, 32'h400, 32'h0, 1'b1, 32'h1111_1111);
        issue(1'b0, 32'h800, 32'h0, 1'b0, 32'hA5A5_0800);
        issue(1'b0, 32'h400, 32'h0, 1'b1, 32'h1111_1111);
        issue(1'b0, 32'h600, 32'h0, 1'b0, 32'hA5A5_0600);
        issue(1'b0, 32'h800, 32'h0, 1'b0, 32'hA5A5_0800);

        // Asynchronous reset two cycles into a fill.
        do_reset();
        @(negedge clk);
        adr_in = 32'h400;
        rd_en_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("fill_mem_rd_en", 32'(mem_rd_en_out), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_mem_rd_en", 32'(mem_rd_en_out), 32'd0);
        check("async_rst_ready", 32'(ready_out), 32'd0);
        check("async_rst_mem_adr", mem_adr_out, 32'd0);
        rd_en_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_hits = '0;
        exp_acc = '0;
        check("after_rst_access_cnt", access_cnt_out, 32'd0);
        issue(1'b0, 32'h400, 32'h0, 1'b0, 32'h1111_1111);

        // Memory answering in the first FILL/WTHRU cycle.
        mem_lat = 1;
        do_reset();
        issue(1'b0, 32'h1004, 32'h0, 1'b0, 32'hA5A5_1004);
        issue(1'b1, 32'h1008, 32'h55AA_55AA, 1'b0, 32'h0);
        issue(1'b0, 32'h1000, 32'h0, 1'b1, 32'hA5A5_1000);

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
